main_fsm: RTL
=============

# main_fsm

Multi-cycle control sequencer for the RV32 subset core (lw, sw, R-type, I-type ALU, beq, jal, lui). It walks each instruction through fetch, decode, execute, memory and writeback steps, and drives the datapath mux selects and write enables. It supplies `ALUOp` to the ALU decoder, which combines it with funct3/funct7 to form `ALUControl`. It sits in the controller next to the ALU decoder and the instruction decoder; all outputs are Moore (decoded from state only, plus `mem_ready` gating where noted).

## Interface

Parameters:
- none

Ports:
- `clk` in 1: core clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `op` in 7: opcode field of the instruction register.
- `mem_ready` in 1: memory has completed the current access this cycle. Used only when the stall feature is enabled.
- `ALUOp` out 2: class code to the ALU decoder. 00 = add, 01 = sub, 10 = funct-decoded, 11 = lui.
- `ALUSrcA` out 2: 00 = PC, 01 = OldPC, 10 = rs1 data, 11 = constant zero.
- `ALUSrcB` out 2: 00 = rs2 data, 01 = ImmExt, 10 = constant 4.
- `ResultSrc` out 2: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `AdrSrc` out 1: 0 = PC, 1 = Result.
- `IRWrite` out 1: instruction register write enable.
- `PCUpdate` out 1: unconditional PC write enable.
- `Branch` out 1: conditional PC write, ANDed with Zero outside this block.
- `RegWrite` out 1: register file write enable.
- `MemWrite` out 1: data memory write enable.
- `illegal_instr` out 1: sticky flag; an unsupported opcode was decoded.
- `state_o` out 4: current state encoding, for debug and bench.

## Operation

State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, LUI=11, ILLEGAL=15.

Outputs not listed for a state are 0, including all 2-bit selects.

| State | Asserted outputs |
|---|---|
| FETCH | IRWrite=1, PCUpdate=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10 |
| DECODE | ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target precompute) |
| MEMADR | ALUSrcA=10, ALUSrcB=01, ALUOp=00 |
| MEMREAD | AdrSrc=1, ResultSrc=00 |
| MEMWB | ResultSrc=01, RegWrite=1 |
| MEMWRITE | AdrSrc=1, ResultSrc=00, MemWrite=1 |
| EXECUTER | ALUSrcA=10, ALUSrcB=00, ALUOp=10 |
| EXECUTEI | ALUSrcA=10, ALUSrcB=01, ALUOp=10 |
| ALUWB | ResultSrc=00, RegWrite=1 |
| BEQ | ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 |
| JAL | ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 |
| LUI | ALUSrcA=11, ALUSrcB=01, ALUOp=11 (0 OR imm) |
| ILLEGAL | all enables 0; `illegal_instr`=1 |

Transitions:
- FETCH → DECODE.
- DECODE dispatches on `op`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BEQ
  - 1101111 → JAL
  - 0110111 → LUI
  - any other value → ILLEGAL
- MEMADR → MEMREAD if `op`=0000011, else → MEMWRITE.
- MEMREAD → MEMWB.
- EXECUTER, EXECUTEI, JAL and LUI each → ALUWB.
- MEMWB, MEMWRITE, ALUWB and BEQ each → FETCH.
- ILLEGAL holds until reset; `illegal_instr` stays 1 throughout.

## Timing

- Reset: when `reset_n`=0 at a rising edge, the next state is FETCH and `illegal_instr` clears to 0.
  - While `reset_n` is low, IRWrite, PCUpdate, Branch, RegWrite and MemWrite are forced to 0 combinationally.
  - The first active FETCH is the first cycle after `reset_n` is seen high.
  - Reset mid-instruction abandons the instruction. No write enable may pulse as a result.
- Latency without stalls:
  - lw = 5 cycles
  - sw, R-type, I-type, jal, lui = 4 cycles
  - beq = 3 cycles
- `op` is sampled only in DECODE and MEMADR. The IR is stable there because IRWrite is 0 outside FETCH.
- No X may appear on any output in any state, including ILLEGAL and undefined encodings.
- Undefined state encodings (12–14) transition to FETCH on the next edge.

## Configuration

- `MAIN_FSM_MEM_STALL_EN` defined:
  - FETCH, MEMREAD and MEMWRITE hold while `mem_ready`=0 and advance on the edge where `mem_ready`=1.
  - In FETCH, IRWrite and PCUpdate are ANDed with `mem_ready`, so the PC advances exactly once per fetch.
  - MemWrite stays asserted for the whole MEMWRITE dwell.
  - Each stall cycle adds 1 to latency.
- `MAIN_FSM_MEM_STALL_EN` undefined:
  - `mem_ready` is ignored and every state lasts exactly 1 cycle.

## Test plan

- Reset then lw:
  - Hold `reset_n`=0 for 2 cycles with `op`=0000011.
  - `state_o` must go 0,1,2,3,4,0.
  - RegWrite=1 only in state 4 with ResultSrc=01; IRWrite=1 only in state 0.
- sw:
  - `op`=0100011.
  - `state_o` must go 0,1,2,5,0.
  - MemWrite=1 for exactly 1 cycle with AdrSrc=1; RegWrite is never 1.
- R-type, beq and lui:
  - R-type: ALUOp=10 with ALUSrcB=00 in state 6, then RegWrite in state 8.
  - beq: ALUOp=01 with Branch=1 in state 9, then FETCH.
  - lui: ALUOp=11 with ALUSrcA=11 in state 11.
- Illegal opcode:
  - Present `op`=1111111 in DECODE.
  - State must go to 15, `illegal_instr`=1, and all enables 0 for 10+ cycles.
  - Pulsing `reset_n`=0 must return to FETCH with `illegal_instr`=0.
- Reset mid-instruction:
  - Assert `reset_n`=0 while in state 8.
  - RegWrite must be 0 that cycle, and the state must be 0 after the edge.
- Stall (`MAIN_FSM_MEM_STALL_EN`):
  - Hold `mem_ready`=0 for 3 cycles in FETCH.
  - The state must stay 0 and PCUpdate must be 0 for those 3 cycles.
  - The cycle `mem_ready`=1: PCUpdate=1 and IRWrite=1 for exactly 1 cycle, then state 1.
  - With the macro undefined, the same stimulus must advance FETCH→DECODE in 1 cycle.

Source files
------------

// File: rtl/main_fsm_if.sv
// Control bundle between the multi-cycle sequencer and the datapath/controller.
// The slave side is the sequencer; the master side drives the opcode and memory handshake.
interface main_fsm_if;
   logic [6:0] op;
   logic       mem_ready;
   logic [1:0] ALUOp;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ResultSrc;
   logic       AdrSrc;
   logic       IRWrite;
   logic       PCUpdate;
   logic       Branch;
   logic       RegWrite;
   logic       MemWrite;
   logic       illegal_instr;
   logic [3:0] state_o;

   modport master (
      output op, mem_ready,
      input  ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCUpdate, Branch,
      input  RegWrite, MemWrite, illegal_instr, state_o
   );

   modport slave (
      input  op, mem_ready,
      output ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCUpdate, Branch,
      output RegWrite, MemWrite, illegal_instr, state_o
   );
endinterface

// File: rtl/main_fsm.sv
// Multi-cycle control sequencer for the RV32 subset core (Moore outputs).
// Define MAIN_FSM_MEM_STALL_EN to make FETCH/MEMREAD/MEMWRITE wait on mem_ready.
module main_fsm (
   input logic       clk,
   input logic       reset_n,
   main_fsm_if.slave bus
);
   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StExecuteR = 4'd6,
      StExecuteI = 4'd7,
      StAluWb    = 4'd8,
      StBeq      = 4'd9,
      StJal      = 4'd10,
      StLui      = 4'd11,
      StIllegal  = 4'd15
   } state_e;

   localparam logic [6:0] OpLoad  = 7'b0000011;
   localparam logic [6:0] OpStore = 7'b0100011;
   localparam logic [6:0] OpRType = 7'b0110011;
   localparam logic [6:0] OpIType = 7'b0010011;
   localparam logic [6:0] OpBeq   = 7'b1100011;
   localparam logic [6:0] OpJal   = 7'b1101111;
   localparam logic [6:0] OpLui   = 7'b0110111;

   state_e state_q, state_d;
   logic   illegal_q, illegal_d;
   logic   mem_go;
   logic   ir_we, pc_we, br_en, rf_we, dm_we;

`ifdef MAIN_FSM_MEM_STALL_EN
   assign mem_go = bus.mem_ready;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = bus.mem_ready;
   assign mem_go = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= StFetch;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StFetch:    if (mem_go) state_d = StDecode;
         StDecode: begin
            case (bus.op)
               OpLoad, OpStore: state_d = StMemAdr;
               OpRType:         state_d = StExecuteR;
               OpIType:         state_d = StExecuteI;
               OpBeq:           state_d = StBeq;
               OpJal:           state_d = StJal;
               OpLui:           state_d = StLui;
               default:         state_d = StIllegal;
            endcase
         end
         StMemAdr:   state_d = (bus.op == OpLoad) ? StMemRead : StMemWrite;
         StMemRead:  if (mem_go) state_d = StMemWb;
         StMemWrite: if (mem_go) state_d = StFetch;
         StExecuteR, StExecuteI, StJal, StLui: state_d = StAluWb;
         StMemWb, StAluWb, StBeq:              state_d = StFetch;
         StIllegal:  state_d = StIllegal;
         default:    state_d = StFetch;
      endcase
      illegal_d = illegal_q | (state_d == StIllegal);
   end

   always_comb begin
      bus.ALUOp     = 2'b00;
      bus.ALUSrcA   = 2'b00;
      bus.ALUSrcB   = 2'b00;
      bus.ResultSrc = 2'b00;
      bus.AdrSrc    = 1'b0;
      ir_we         = 1'b0;
      pc_we         = 1'b0;
      br_en         = 1'b0;
      rf_we         = 1'b0;
      dm_we         = 1'b0;
      case (state_q)
         StFetch: begin
            // Gate with mem_ready so the PC advances once per fetch under stalls.
            ir_we         = mem_go;
            pc_we         = mem_go;
            bus.ALUSrcB   = 2'b10;
            bus.ResultSrc = 2'b10;
         end
         StDecode: begin
            bus.ALUSrcA = 2'b01;
            bus.ALUSrcB = 2'b01;
         end
         StMemAdr: begin
            bus.ALUSrcA = 2'b10;
            bus.ALUSrcB = 2'b01;
         end
         StMemRead:  bus.AdrSrc = 1'b1;
         StMemWb: begin
            bus.ResultSrc = 2'b01;
            rf_we         = 1'b1;
         end
         StMemWrite: begin
            bus.AdrSrc = 1'b1;
            dm_we      = 1'b1;
         end
         StExecuteR: begin
            bus.ALUSrcA = 2'b10;
            bus.ALUOp   = 2'b10;
         end
         StExecuteI: begin
            bus.ALUSrcA = 2'b10;
            bus.ALUSrcB = 2'b01;
            bus.ALUOp   = 2'b10;
         end
         StAluWb:    rf_we = 1'b1;
         StBeq: begin
            bus.ALUSrcA = 2'b10;
            bus.ALUOp   = 2'b01;
            br_en       = 1'b1;
         end
         StJal: begin
            bus.ALUSrcA = 2'b01;
            bus.ALUSrcB = 2'b10;
            pc_we       = 1'b1;
         end
         StLui: begin
            bus.ALUSrcA = 2'b11;
            bus.ALUSrcB = 2'b01;
            bus.ALUOp   = 2'b11;
         end
         default: ;
      endcase
      bus.IRWrite  = ir_we & reset_n;
      bus.PCUpdate = pc_we & reset_n;
      bus.Branch   = br_en & reset_n;
      bus.RegWrite = rf_we & reset_n;
      bus.MemWrite = dm_we & reset_n;
   end

   assign bus.illegal_instr = illegal_q;
   assign bus.state_o       = state_q;
endmodule
